// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: stall-vector control (MODE 0) or valid/ready with skid (MODE 1).
// Optional performance counters enabled by defining PIPE_STAGE_PERF_CNT_EN.
module pipe_stage_reg #(
    parameter int unsigned        DATA_W  = 128,
    parameter int unsigned        STALL_W = 6,
    parameter int unsigned        STAGE   = 2,
    parameter int unsigned        MODE    = 0,
    parameter logic [DATA_W-1:0]  BUBBLE  = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    input  logic               out_ready,
    output logic [31:0]        bubble_cnt,
    output logic [31:0]        hold_cnt
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              us, ds, accept, drain;
    logic              bubble_inc, hold_inc;

    assign us = stall[STAGE];
    assign ds = stall[STAGE+1];

    // Elastic mode never looks at the stall vector.
    logic unused_stall;
    assign unused_stall = ^stall;

    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            if (MODE == 0) in_ready = ~us;
            else           in_ready = ~skid_valid_q;
        end
    end

    assign accept = in_valid & in_ready;
    assign drain  = out_valid_q & out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        bubble_inc   = 1'b0;
        hold_inc     = 1'b0;
        if (flush) begin
            out_valid_d  = 1'b0;
            out_data_d   = BUBBLE;
            skid_valid_d = 1'b0;
            skid_data_d  = BUBBLE;
            bubble_inc   = 1'b1;
        end else if (MODE == 0) begin
            if (us && !ds) begin
                out_valid_d = 1'b0;
                out_data_d  = BUBBLE;
                bubble_inc  = 1'b1;
            end else if (us && ds) begin
                hold_inc = out_valid_q;
            end else begin
                // us=0 with ds=1 is illegal ctrl but still loads, like the legacy stages.
                out_valid_d = in_valid;
                out_data_d  = in_data;
            end
        end else begin
            if (!out_valid_q || drain) begin
                if (skid_valid_q) begin
                    out_valid_d  = 1'b1;
                    out_data_d   = skid_data_q;
                    skid_valid_d = accept;
                    if (accept) skid_data_d = in_data;
                end else if (accept) begin
                    out_valid_d = 1'b1;
                    out_data_d  = in_data;
                end else begin
                    out_valid_d = 1'b0;
                    out_data_d  = BUBBLE;
                end
            end else begin
                hold_inc = 1'b1;
                if (accept) begin
                    skid_valid_d = 1'b1;
                    skid_data_d  = in_data;
                end
            end
            bubble_inc = out_valid_q & ~out_valid_d & ~drain;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= BUBBLE;
            skid_valid_q <= 1'b0;
            skid_data_q  <= BUBBLE;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef PIPE_STAGE_PERF_CNT_EN
    logic [31:0] bubble_cnt_q, hold_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_q <= '0;
            hold_cnt_q   <= '0;
        end else begin
            if (bubble_inc) bubble_cnt_q <= bubble_cnt_q + 32'd1;
            if (hold_inc)   hold_cnt_q   <= hold_cnt_q + 32'd1;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign hold_cnt   = hold_cnt_q;
`else
    logic unused_perf;
    assign unused_perf = bubble_inc ^ hold_inc;
    assign bubble_cnt  = '0;
    assign hold_cnt    = '0;
`endif

endmodule
